fir_mc_decim: RTL and testbench

Time-multiplexed, multi-channel, decimating FIR filter, parametrised in data width, coefficient width, maximum tap count and channel count. It is the next-generation filter stage of the lock-in datapath. The block holds a runtime-loadable coefficient RAM and one circular history buffer per channel, and computes each output with a single MAC over `n_taps` cycles. Outputs are saturated, tagged with their channel, and gated until each channel's history is full.

---
 rtl/fir_mc_decim.sv | 173 +++++++++++++++++
 tb/tb_fir_mc_decim.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_decim.sv
// Time-multiplexed multi-channel decimating FIR: one MAC per output over N cycles,
// per-channel circular history, saturated and channel-tagged results.
module fir_mc_decim #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 256,
  parameter int CH    = 2,
  parameter int ACC_W = 48,
  parameter int SHIFT = 16,
  localparam int TAW  = $clog2(TAPS),
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic [15:0]    n_taps,
  input  logic [7:0]     decim,
  input  logic           coef_we,
  input  logic [TAW-1:0] coef_addr,
  input  logic [CW-1:0]  coef_data,
  output logic           coef_drop,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  output logic           out_sat,
  output logic           busy
);
  localparam int FW = TAW + 1;
  localparam int PW = DW + CW;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  function automatic logic [DW:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s, hi, lo;
    s  = a >>> SHIFT;
    hi = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (s > hi)      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (s < lo) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    else             return {1'b0, s[DW-1:0]};
  endfunction

  state_t          state_q;
  logic            in_ready_q, out_valid_q, out_sat_q, coef_drop_q, clr_pend_q, drn_q;
  logic [CHW-1:0]  ch_q, out_ch_q;
  logic [DW-1:0]   out_data_q;
  logic [FW-1:0]   n_q;
  logic [TAW-1:0]  k_q, base_q;
  logic [FW-1:0]   fill_q [CH];
  logic [TAW-1:0]  wp_q   [CH];
  logic [7:0]      dcnt_q [CH];
  logic            vld_p0, vld_p1;

  logic signed [DW-1:0]    hist_q [CH][TAPS];
  logic signed [CW-1:0]    coef_q [TAPS];
  logic signed [DW-1:0]    hist_p0;
  logic signed [CW-1:0]    coef_p0;
  logic signed [PW-1:0]    prod_p1;
  logic signed [ACC_W-1:0] acc_q;

  logic [FW-1:0] n_eff, fill_d;
  logic [7:0]    d_eff;
  logic          take, wrap, trig, flush;

  always_comb begin
    n_eff = FW'(n_taps);
    if (n_taps == 16'd0)           n_eff = FW'(1);
    else if (32'(n_taps) > TAPS)   n_eff = FW'(TAPS);
    d_eff  = (decim == 8'd0) ? 8'd1 : decim;
    take   = rst_n & in_valid & in_ready_q & ~clear & (32'(in_ch) < CH);
    fill_d = (fill_q[in_ch] == FW'(TAPS)) ? fill_q[in_ch] : fill_q[in_ch] + FW'(1);
    wrap   = dcnt_q[in_ch] >= (d_eff - 8'd1);
    trig   = take & wrap & (fill_d >= n_eff);
    flush  = ((state_q == S_IDLE) & clear) | ((state_q == S_OUT) & (clear | clr_pend_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      coef_drop_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        fill_q[i] <= '0;
        wp_q[i]   <= '0;
        dcnt_q[i] <= '0;
      end
    end else begin
      coef_drop_q <= coef_we & ~in_ready_q;
      out_valid_q <= 1'b0;
      vld_p0      <= (state_q == S_MAC);
      vld_p1      <= vld_p0;
      if (clear && state_q != S_IDLE) clr_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // ready returns one cycle after the output strobe
          in_ready_q <= 1'b1;
          if (take) begin
            wp_q[in_ch]   <= wp_q[in_ch] + TAW'(1);
            fill_q[in_ch] <= fill_d;
            dcnt_q[in_ch] <= wrap ? 8'd0 : dcnt_q[in_ch] + 8'd1;
            if (trig) begin
              state_q    <= S_MAC;
              in_ready_q <= 1'b0;
              ch_q       <= in_ch;
              n_q        <= n_eff;
              base_q     <= wp_q[in_ch];
              k_q        <= '0;
            end
          end
        end
        S_MAC: begin
          k_q <= k_q + TAW'(1);
          if ({1'b0, k_q} == n_q - FW'(1)) begin
            state_q <= S_DRAIN;
            drn_q   <= 1'b0;
          end
        end
        S_DRAIN: begin
          drn_q <= 1'b1;
          if (drn_q) state_q <= S_OUT;
        end
        S_OUT: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          {out_sat_q, out_data_q} <= sat_fn(acc_q);
          clr_pend_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (flush) begin
        for (int i = 0; i < CH; i++) begin
          fill_q[i] <= '0;
          wp_q[i]   <= '0;
          dcnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (coef_we && in_ready_q) coef_q[coef_addr] <= coef_data;
    if (take) hist_q[in_ch][wp_q[in_ch]] <= in_data;
    // p0: RAM read, k = 0 is the newest sample
    hist_p0 <= hist_q[ch_q][base_q - k_q];
    coef_p0 <= coef_q[k_q];
    // p1: product
    prod_p1 <= hist_p0 * coef_p0;
    // accumulate
    if (trig)        acc_q <= '0;
    else if (vld_p1) acc_q <= acc_q + {{(ACC_W-PW){prod_p1[PW-1]}}, prod_p1};
  end

  assign in_ready  = in_ready_q;
  assign busy      = ~in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign coef_drop = coef_drop_q;

endmodule

// File: tb/tb_fir_mc_decim.sv
// Bench for fir_mc_decim: vector table for impulse/warm-up/saturation, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_fir_mc_decim;
  logic        clk = 1'b0;
  logic        rst_n, clear, coef_we, in_valid;
  logic [15:0] n_taps;
  logic [7:0]  decim, coef_addr;
  logic [15:0] coef_data, in_data;
  logic [0:0]  in_ch;
  logic        coef_drop, in_ready, out_valid, out_sat, busy;
  logic [0:0]  out_ch;
  logic [15:0] out_data;

  fir_mc_decim dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .n_taps(n_taps), .decim(decim),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_drop(coef_drop),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int val; bit sat; } exp_t;
  typedef struct { int ch; int data; bit trig; bit chk; int val; bit sat; } vec_t;

  int   total = 0, bad = 0;
  int   mc [256];
  int   mq [2][$];
  int   mdc [2];
  exp_t exp_q [$];
  exp_t e;
  int   oc [2];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model_flush();
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      mdc[c] = 0;
    end
  endfunction

  // Filter definition applied directly to the sample history of the channel
  function automatic void model_push(input int ch, input int d);
    int     n, dd, sz;
    bit     wr;
    longint acc, s;
    n  = (n_taps == 0) ? 1 : ((n_taps > 256) ? 256 : int'(n_taps));
    dd = (decim == 0) ? 1 : int'(decim);
    mq[ch].push_back(d);
    if (mq[ch].size() > 256) void'(mq[ch].pop_front());
    wr = (mdc[ch] >= dd - 1);
    mdc[ch] = wr ? 0 : mdc[ch] + 1;
    sz = mq[ch].size();
    if (wr && sz >= n) begin
      acc = 0;
      for (int k = 0; k < n; k++) acc += longint'(mc[k]) * longint'(mq[ch][sz-1-k]);
      s = acc >>> 16;
      if (s > 32767)       exp_q.push_back('{ch, 32767, 1'b1});
      else if (s < -32768) exp_q.push_back('{ch, -32768, 1'b1});
      else                 exp_q.push_back('{ch, int'(s), 1'b0});
    end
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      oc[out_ch]++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe actual ch=%0d data=%0d required=none", out_ch, $signed(out_data));
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_data", $signed(out_data), e.val);
        chk("out_sat", out_sat, e.sat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic send(input int ch, input int d);
    int w = 0;
    while (!in_ready && w < 600) begin @(negedge clk); w++; end
    if (!in_ready) chk("ready_wait", 0, 1);
    in_valid = 1'b1; in_ch = ch[0:0]; in_data = d[15:0];
    @(posedge clk);
    model_push(ch, d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the handshake edge
  task automatic check_lat(input int n);
    bit ok = 1'b1;
    int first = -1;
    for (int j = 1; j <= n + 5; j++) begin
      if (j <= n + 4 && in_ready) ok = 1'b0;
      if (j == n + 5 && !in_ready) ok = 1'b0;
      if (busy == in_ready) ok = 1'b0;
      if (out_valid && first < 0) first = j;
      if (j < n + 5) @(negedge clk);
    end
    chk("strobe_latency", first, n + 4);
    chk("ready_window", ok, 1);
  endtask

  task automatic check_quiet(input int n);
    bit ok = 1'b1;
    for (int j = 1; j <= n + 6; j++) begin
      if (!in_ready || out_valid) ok = 1'b0;
      @(negedge clk);
    end
    chk("quiet", ok, 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!in_ready && w < 600) begin @(negedge clk); w++; end
    chk("idle_reached", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic load_coef(input int k, input int v);
    coef_we = 1'b1; coef_addr = k[7:0]; coef_data = v[15:0];
    @(negedge clk);
    coef_we = 1'b0;
    mc[k] = v;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_flush();
  endtask

  vec_t tv [15];
  logic [15:0] r16;
  int rd;

  initial begin
    tv[0]  = '{0, 0,      1'b0, 1'b0, 0, 1'b0};
    tv[1]  = '{0, 0,      1'b0, 1'b0, 0, 1'b0};
    tv[2]  = '{0, 0,      1'b0, 1'b0, 0, 1'b0};
    tv[3]  = '{0, 1000,   1'b1, 1'b1, 250, 1'b0};
    tv[4]  = '{0, 0,      1'b1, 1'b1, 125, 1'b0};
    tv[5]  = '{0, 0,      1'b1, 1'b1, 62, 1'b0};
    tv[6]  = '{0, 0,      1'b1, 1'b1, 31, 1'b0};
    tv[7]  = '{0, 32767,  1'b1, 1'b0, 0, 1'b0};
    tv[8]  = '{0, 32767,  1'b1, 1'b0, 0, 1'b0};
    tv[9]  = '{0, 32767,  1'b1, 1'b0, 0, 1'b0};
    tv[10] = '{0, 32767,  1'b1, 1'b1, 32767, 1'b1};
    tv[11] = '{0, -32768, 1'b1, 1'b0, 0, 1'b0};
    tv[12] = '{0, -32768, 1'b1, 1'b0, 0, 1'b0};
    tv[13] = '{0, -32768, 1'b1, 1'b0, 0, 1'b0};
    tv[14] = '{0, -32768, 1'b1, 1'b1, -32768, 1'b1};

    rst_n = 1'b0; clear = 1'b0; coef_we = 1'b0; in_valid = 1'b0;
    n_taps = 16'd4; decim = 8'd1; coef_addr = '0; coef_data = '0; in_ch = '0; in_data = '0;
    model_flush();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_coef_drop", coef_drop, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse response, warm-up gating, saturation
    load_coef(0, 16384); load_coef(1, 8192); load_coef(2, 4096); load_coef(3, 2048);
    for (int i = 0; i < 15; i++) begin
      if (i == 7) for (int k = 0; k < 4; k++) load_coef(k, 32767);
      send(tv[i].ch, tv[i].data);
      if (tv[i].trig) check_lat(4);
      else            check_quiet(4);
      if (tv[i].chk) begin
        chk("vec_data", $signed(out_data), tv[i].val);
        chk("vec_sat", out_sat, tv[i].sat);
      end
    end

    // coefficient write while busy is dropped
    load_coef(0, 1000); load_coef(1, 2000); load_coef(2, -3000); load_coef(3, 4000);
    send(0, 12345);
    coef_we = 1'b1; coef_addr = 8'd0; coef_data = 16'd0;
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_drop_pulse", coef_drop, 1);
    @(negedge clk);
    chk("coef_drop_end", coef_drop, 0);
    wait_idle();
    send(0, 23456);
    wait_idle();

    // decimation by 3 with interleaved channels
    do_clear();
    decim = 8'd3;
    for (int i = 0; i < 12; i++) begin r16 = 16'($urandom); send(i % 2, int'($signed(r16))); end
    wait_idle();
    oc[0] = 0; oc[1] = 0;
    for (int i = 0; i < 12; i++) begin r16 = 16'($urandom); send(i % 2, int'($signed(r16))); end
    wait_idle();
    chk("decim_outs_ch0", oc[0], 2);
    chk("decim_outs_ch1", oc[1], 2);

    // clear together with a handshake discards the sample
    decim = 8'd1; n_taps = 16'd2;
    clear = 1'b1; in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd777;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_flush();
    send(0, 5);
    check_quiet(2);
    send(0, 6);
    check_lat(2);

    // randomized traffic
    for (int blk = 0; blk < 3; blk++) begin
      wait_idle();
      do_clear();
      decim = (blk == 0) ? 8'd0 : 8'(blk + 1);
      for (int k = 0; k < 8; k++) load_coef(k, int'($urandom_range(16383, 0)) - 8192);
      for (int i = 0; i < 60; i++) begin
        rd = int'($urandom_range(9, 0));
        n_taps = (rd == 0) ? 16'd0 : ((rd == 9) ? 16'd300 : 16'(rd));
        r16 = 16'($urandom);
        send(int'($urandom_range(1, 0)), int'($signed(r16)));
      end
    end
    wait_idle();

    // reset in the middle of a MAC
    decim = 8'd1; n_taps = 16'd4;
    for (int i = 0; i < 4; i++) send(0, 100 * (i + 1));
    rst_n = 1'b0;
    model_flush();
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    check_quiet(14);
    for (int i = 0; i < 3; i++) begin send(0, 300 + i); check_quiet(4); end
    send(0, 400);
    check_lat(4);

    wait_idle();
    chk("expected_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
